// File: rtl/bht_sat_predictor.sv
// bht_sat_predictor: branch history table of 2^INDEX_W saturating counters.
// After reset an init sweep writes every entry to weakly-taken, then the
// table serves 1-cycle registered lookups and same-edge training updates.
// Optional build macro GSHARE_EN: XOR a global taken/not-taken history into
// the lookup index (updates always use the index handed back by pred_index).

// One table entry: a CNT_W-bit saturating counter.
module bht_cnt_entry #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             init_wr,
   input  logic             upd_en,
   input  logic             upd_taken,
   output logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(1) << (CNT_W - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // init sweep wins over training; training steps toward the outcome and sticks at the ends
   always_comb begin
      cnt_d = cnt_q;
      if (init_wr) begin
         cnt_d = WEAK_T;
      end else if (upd_en) begin
         if (upd_taken) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         end else begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // counter storage; contents are defined by the init sweep, not by reset
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

module bht_sat_predictor #(
   parameter int INDEX_W = 3,
   parameter int CNT_W   = 2,
   parameter int GHR_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               lk_valid,
   input  logic [INDEX_W-1:0] lk_addr,
   input  logic               upd_valid,
   input  logic [INDEX_W-1:0] upd_index,
   input  logic               upd_taken,
   output logic               ready,
   output logic               pred_valid,
   output logic               pred_taken,
   output logic [CNT_W-1:0]   pred_state,
   output logic [INDEX_W-1:0] pred_index
);
   localparam int DEPTH = 1 << INDEX_W;
   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);

   typedef enum logic {S_INIT, S_READY} state_t;

   state_t                    state_q, state_d;
   logic [INDEX_W-1:0]        ptr_q, ptr_d;
   logic [DEPTH-1:0][CNT_W-1:0] tbl;
   logic [INDEX_W-1:0]        lk_idx;
   logic                      lk_fire, upd_fire;

   logic                      pred_valid_q, pred_valid_d;
   logic                      pred_taken_q, pred_taken_d;
   logic [CNT_W-1:0]          pred_state_q, pred_state_d;
   logic [INDEX_W-1:0]        pred_index_q, pred_index_d;

   // parameter sanity, caught at elaboration
   generate
      if (CNT_W < 1) begin : g_bad_cnt
         $error("bht_sat_predictor: CNT_W must be >= 1");
      end
      if (GHR_W < 1 || GHR_W > INDEX_W) begin : g_bad_ghr
         $error("bht_sat_predictor: GHR_W must be in 1..INDEX_W");
      end
   endgenerate

   // requests only count once the table is initialised and not in reset
   assign lk_fire  = (state_q == S_READY) & lk_valid & ~rst;
   assign upd_fire = (state_q == S_READY) & upd_valid & ~rst;

`ifdef GSHARE_EN
   logic [GHR_W-1:0] ghr_q, ghr_d;

   // history shifts in every honoured outcome; lookups this cycle see the old value
   always_comb begin
      ghr_d = ghr_q;
      if (upd_fire) ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
   end

   // history register
   always_ff @(posedge clk) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
   end

   assign lk_idx = lk_addr ^ INDEX_W'(ghr_q);
`else
   assign lk_idx = lk_addr;
`endif

   // init sweep: one entry per cycle, then serve forever until reset
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_INIT: begin
            ptr_d = ptr_q + INDEX_W'(1);
            if (ptr_q == LAST_IDX) state_d = S_READY;
         end
         S_READY: ;
         default: state_d = S_INIT;
      endcase
   end

   // FSM and sweep pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // counter array; the read for a lookup is taken before the same-edge update lands
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_ent
         bht_cnt_entry #(.CNT_W(CNT_W)) u_ent (
            .clk       (clk),
            .init_wr   ((state_q == S_INIT) && !rst && (ptr_q == INDEX_W'(i))),
            .upd_en    (upd_fire && (upd_index == INDEX_W'(i))),
            .upd_taken (upd_taken),
            .cnt       (tbl[i])
         );
      end
   endgenerate

   // prediction capture: valid pulses per lookup, payload holds between lookups
   always_comb begin
      pred_valid_d = lk_fire;
      pred_taken_d = pred_taken_q;
      pred_state_d = pred_state_q;
      pred_index_d = pred_index_q;
      if (lk_fire) begin
         pred_index_d = lk_idx;
         pred_state_d = tbl[lk_idx];
         pred_taken_d = tbl[lk_idx][CNT_W-1];
      end
   end

   // prediction output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_state_q <= '0;
         pred_index_q <= '0;
      end else begin
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
         pred_state_q <= pred_state_d;
         pred_index_q <= pred_index_d;
      end
   end

   assign ready      = (state_q == S_READY);
   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_state = pred_state_q;
   assign pred_index = pred_index_q;
endmodule

// File: tb/tb_bht_sat_predictor.sv
// Scoreboard bench for bht_sat_predictor: the stimulus process runs a
// behavioural table model and queues the expected outputs after every edge;
// a monitor pops and compares them on the following falling edge.
module tb_bht_sat_predictor;
   localparam int INDEX_W = 3;
   localparam int CNT_W   = 2;
   localparam int GHR_W   = 3;
   localparam int DEPTH   = 1 << INDEX_W;
   localparam int CMAX    = (1 << CNT_W) - 1;
   localparam int WEAK    = 1 << (CNT_W - 1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               lk_valid = 1'b0;
   logic [INDEX_W-1:0] lk_addr = '0;
   logic               upd_valid = 1'b0;
   logic [INDEX_W-1:0] upd_index = '0;
   logic               upd_taken = 1'b0;
   logic               ready, pred_valid, pred_taken;
   logic [CNT_W-1:0]   pred_state;
   logic [INDEX_W-1:0] pred_index;

   typedef struct {
      bit rdy;
      bit vld;
      bit tkn;
      int st;
      int idx;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   m_tbl[DEPTH];
   int   m_init_cnt = 0;
   int   m_ghr = 0;

   always #5 clk = ~clk;

   bht_sat_predictor #(.INDEX_W(INDEX_W), .CNT_W(CNT_W), .GHR_W(GHR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .lk_valid   (lk_valid),
      .lk_addr    (lk_addr),
      .upd_valid  (upd_valid),
      .upd_index  (upd_index),
      .upd_taken  (upd_taken),
      .ready      (ready),
      .pred_valid (pred_valid),
      .pred_taken (pred_taken),
      .pred_state (pred_state),
      .pred_index (pred_index)
   );

   // one clock of stimulus; the model advances on the same edge as the DUT
   task automatic cyc(input bit r, input bit lv, input int la, input bit uv, input int ui, input bit ut);
      int idx;
      @(negedge clk);
      rst       = r;
      lk_valid  = lv;
      lk_addr   = la[INDEX_W-1:0];
      upd_valid = uv;
      upd_index = ui[INDEX_W-1:0];
      upd_taken = ut;
      @(posedge clk);
      if (r) begin
         m_init_cnt = 0;
         m_ghr      = 0;
         cur.rdy = 0; cur.vld = 0; cur.tkn = 0; cur.st = 0; cur.idx = 0;
      end else if (m_init_cnt < DEPTH) begin
         m_tbl[m_init_cnt] = WEAK;
         m_init_cnt++;
         cur.vld = 0;
         cur.rdy = (m_init_cnt == DEPTH);
      end else begin
         cur.rdy = 1;
         cur.vld = lv;
         if (lv) begin
`ifdef GSHARE_EN
            idx = (la ^ m_ghr) % DEPTH;
`else
            idx = la % DEPTH;
`endif
            cur.idx = idx;
            cur.st  = m_tbl[idx];
            cur.tkn = (m_tbl[idx] >= WEAK);
         end
         if (uv) begin
            if (ut) m_tbl[ui % DEPTH] = (m_tbl[ui % DEPTH] == CMAX) ? CMAX : m_tbl[ui % DEPTH] + 1;
            else    m_tbl[ui % DEPTH] = (m_tbl[ui % DEPTH] == 0)    ? 0    : m_tbl[ui % DEPTH] - 1;
            m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << GHR_W);
         end
      end
      q.push_back(cur);
   endtask

   task automatic look(input int a);
      cyc(0, 1, a, 0, 0, 0);
   endtask

   task automatic train(input int i, input bit t);
      cyc(0, 0, 0, 1, i, t);
   endtask

   // monitor: every edge has one queued expectation covering all outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (ready !== e.rdy || pred_valid !== e.vld || pred_taken !== e.tkn ||
                pred_state !== e.st[CNT_W-1:0] || pred_index !== e.idx[INDEX_W-1:0]) begin
               n_fail++;
               $display("FAIL outputs t=%0t: got rdy=%b vld=%b tkn=%b st=%0d idx=%0d, want rdy=%b vld=%b tkn=%b st=%0d idx=%0d",
                        $time, ready, pred_valid, pred_taken, pred_state, pred_index,
                        e.rdy, e.vld, e.tkn, e.st, e.idx);
            end
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, then init sweep with requests held high (must be ignored)
      cyc(1, 1, 5, 1, 5, 1);
      cyc(1, 1, 2, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, i, 1, i, 0);
      for (int i = 0; i < DEPTH; i++) look(i);

      // saturation at both ends on index 5
      for (int i = 0; i < 3; i++) train(5, 1);
      look(5);
      for (int i = 0; i < 4; i++) train(5, 0);
      look(5);
      train(5, 0);
      look(5);

      // same-cycle lookup and update on index 2: read-before-write
      cyc(0, 1, 2, 1, 2, 0);
      look(2);
      // lookup and update on different indices
      cyc(0, 1, 4, 1, 6, 1);
      look(6);

      // single-cycle valid pulse, payload holds
      look(3);
      for (int i = 0; i < 3; i++) cyc(0, 0, 7, 0, 0, 0);

      // reset mid-init after pre-training
      train(1, 1); train(6, 0); train(6, 0);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, i, 1, i, 1);
      cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) look(i);

`ifdef GSHARE_EN
      // history T,T,N -> 3'b110; lookup 3'b011 maps to 3'b101
      train(0, 1); train(0, 1); train(0, 0);
      look(3);
`endif

      // randomized traffic with rare resets
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 149) == 0), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1));
      end

      @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
